// File: rtl/ws2812_tx.sv
// ---------------------------------------------------------------------------
// ws2812_tx
//
// Serial line driver for a WS2812 / NeoPixel chain running from the 25 MHz
// board oscillator. 24-bit GRB pixel words arrive over a valid/ready stream
// and are shifted out MSB first as pulse-width-coded NRZ bits on one pin.
// A '0' bit is high for T0H cycles and a '1' bit is high for T1H cycles.
// Every bit period is TBIT cycles long. After a word flagged as last, the
// line is held low for TLATCH cycles so the LEDs latch the frame.
//
// Ports
//   osc25m     in   system clock, 25 MHz
//   rst        in   synchronous active-high reset; forces a full latch interval
//   pix_data   in   pixel word {G, R, B}; bit DATA_W-1 is sent first
//   pix_valid  in   pix_data / pix_last valid
//   pix_last   in   this pixel ends the frame
//   pix_ready  out  a word is accepted on an edge where pix_valid is also high
//   dout       out  registered serial line to the first LED
//   busy       out  high whenever the driver is not idle
//   underrun   out  one-cycle pulse: a non-last pixel ended with no successor
// ---------------------------------------------------------------------------
module ws2812_tx #(
   parameter int DATA_W = 24,
   parameter int T0H    = 9,
   parameter int T1H    = 18,
   parameter int TBIT   = 31,
   parameter int TLATCH = 2000
) (
   input  logic              osc25m,
   input  logic              rst,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_valid,
   input  logic              pix_last,
   output logic              pix_ready,
   output logic              dout,
   output logic              busy,
   output logic              underrun
);

   localparam int BCNT_W = $clog2(TBIT);
   localparam int LCNT_W = $clog2(TLATCH);
   localparam int IDX_W  = 5;

   localparam logic [BCNT_W-1:0] BIT_LAST   = BCNT_W'(TBIT - 1);
   localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(TLATCH - 1);
   localparam logic [IDX_W-1:0]  IDX_FIRST  = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                last_q, last_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [LCNT_W-1:0]   latch_cnt_q, latch_cnt_d;
   logic                ready_int;
   logic                line_p0;
   logic                und_d;
   logic                bit_end;
   logic                word_end;

   // High time of the bit currently on the line.
   function automatic logic [BCNT_W-1:0] high_time(input logic b);
      return b ? BCNT_W'(T1H) : BCNT_W'(T0H);
   endfunction

   assign bit_end  = (bit_cnt_q == BIT_LAST);
   assign word_end = bit_end && (bit_idx_q == '0);

   // A word offered while reset is asserted is never consumed, so the
   // handshake is masked for the reset cycle.
   assign pix_ready = ready_int & ~rst;
   assign busy      = (state_q != IDLE);

   // ---- stage p0: next-state, counters and line level ----
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      bit_idx_d   = bit_idx_q;
      bit_cnt_d   = bit_cnt_q;
      latch_cnt_d = latch_cnt_q;
      ready_int   = 1'b0;
      line_p0     = 1'b0;
      und_d       = 1'b0;

      case (state_q)
         IDLE: begin
            ready_int = 1'b1;
            if (pix_valid) begin
               state_d   = SEND;
               shreg_d   = pix_data;
               last_d    = pix_last;
               bit_idx_d = IDX_FIRST;
               bit_cnt_d = '0;
            end
         end

         SEND: begin
            // The bit being sent is always the MSB of the shift register.
            line_p0 = (bit_cnt_q < high_time(shreg_q[DATA_W-1]));
            if (!bit_end) begin
               bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end else if (!word_end) begin
               bit_cnt_d = '0;
               bit_idx_d = bit_idx_q - IDX_W'(1);
               shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            end else if (last_q) begin
               state_d     = LATCH;
               bit_cnt_d   = '0;
               latch_cnt_d = '0;
            end else begin
               // Single-cycle window in which a following pixel can chain
               // on with no gap between its first bit and our last bit.
               ready_int = 1'b1;
               bit_cnt_d = '0;
               if (pix_valid) begin
                  shreg_d   = pix_data;
                  last_d    = pix_last;
                  bit_idx_d = IDX_FIRST;
               end else begin
                  state_d = IDLE;
                  und_d   = 1'b1;
               end
            end
         end

         LATCH: begin
            if (latch_cnt_q == LATCH_LAST) begin
               state_d     = IDLE;
               latch_cnt_d = '0;
            end else begin
               latch_cnt_d = latch_cnt_q + LCNT_W'(1);
            end
         end

         default: begin
            // Unreachable encoding: recover through a full latch interval.
            state_d     = LATCH;
            latch_cnt_d = '0;
            bit_cnt_d   = '0;
         end
      endcase
   end

   // ---- stage p1: control registers and registered line ----
   always_ff @(posedge osc25m) begin
      if (rst) begin
         state_q     <= LATCH;
         last_q      <= 1'b0;
         bit_idx_q   <= '0;
         bit_cnt_q   <= '0;
         latch_cnt_q <= '0;
         dout        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         bit_idx_q   <= bit_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         latch_cnt_q <= latch_cnt_d;
         dout        <= line_p0;
         underrun    <= und_d;
      end
   end

   // Pixel data is only meaningful in SEND and is always reloaded on the
   // accepting handshake, so it carries no reset.
   always_ff @(posedge osc25m) begin
      shreg_q <= shreg_d;
   end

endmodule

// File: tb/tb_ws2812_tx.sv
`timescale 1ns/1ps
module tb_ws2812_tx;
   localparam int T0H    = 9;
   localparam int T1H    = 18;
   localparam int TBIT   = 31;
   localparam int TLATCH = 2000;
   localparam int WORD   = 24 * TBIT;
   localparam int LOGN   = 65536;
   localparam int M_IDLE  = 0;
   localparam int M_SEND  = 1;
   localparam int M_LATCH = 2;

   logic        osc25m = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_last = 1'b0;
   logic        pix_ready, dout, busy, underrun;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   bit dout_log  [LOGN];
   bit ready_log [LOGN];
   bit und_log   [LOGN];

   ws2812_tx #(.DATA_W(24), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)) dut (
      .osc25m(osc25m), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_last(pix_last), .pix_ready(pix_ready), .dout(dout), .busy(busy),
      .underrun(underrun)
   );

   always #20 osc25m = ~osc25m;
   always @(posedge osc25m) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The expected line is a queue of per-cycle levels: each accepted word
   // appends its 744-cycle waveform; dout shows that level one cycle later.
   int m_mode = M_IDLE;
   int m_deadline = 0;
   bit m_last = 1'b0;
   bit m_prev = 1'b0;
   bit m_und = 1'b0;
   bit m_on = 1'b0;
   bit q_line[$];

   function automatic void m_start(input logic [23:0] d, input logic l, input int now);
      int h;
      m_mode = M_SEND;
      m_deadline = now + WORD;
      m_last = l;
      for (int b = 23; b >= 0; b--) begin
         h = d[b] ? T1H : T0H;
         for (int k = 0; k < TBIT; k++) q_line.push_back(k < h);
      end
   endfunction

   initial begin
      bit e_line, e_ready;
      forever begin
         @(negedge osc25m);
         if (cyc < LOGN) begin
            dout_log[cyc]  = dout;
            ready_log[cyc] = pix_ready;
            und_log[cyc]   = underrun;
         end
         if (m_on) begin
            e_line  = (q_line.size() > 0) ? q_line.pop_front() : 1'b0;
            e_ready = !rst && (m_mode == M_IDLE ||
                               (m_mode == M_SEND && cyc == m_deadline && !m_last));
            chk("dout", int'(dout), int'(m_prev));
            chk("pix_ready", int'(pix_ready), int'(e_ready));
            chk("busy", int'(busy), int'(m_mode != M_IDLE));
            chk("underrun", int'(underrun), int'(m_und));
            m_und  = 1'b0;
            m_prev = e_line;
            if (rst) begin
               m_mode = M_LATCH;
               m_deadline = cyc + TLATCH;
               q_line.delete();
               m_prev = 1'b0;
            end else begin
               case (m_mode)
                  M_IDLE: if (pix_valid) m_start(pix_data, pix_last, cyc);
                  M_SEND: if (cyc == m_deadline) begin
                     if (m_last) begin
                        m_mode = M_LATCH;
                        m_deadline = cyc + TLATCH;
                     end else if (pix_valid) begin
                        m_start(pix_data, pix_last, cyc);
                     end else begin
                        m_mode = M_IDLE;
                        m_und = 1'b1;
                     end
                  end
                  default: if (cyc == m_deadline) m_mode = M_IDLE;
               endcase
            end
         end else if (rst) begin
            m_on = 1'b1;
            m_mode = M_LATCH;
            m_deadline = cyc + TLATCH;
            m_prev = 1'b0;
         end
      end
   end

   // ---------------- log helpers ----------------
   function automatic int run_len(input int s);
      int n = 0;
      while (s >= 0 && s + n < LOGN && n < 64 && dout_log[s + n]) n++;
      return n;
   endfunction

   function automatic int ones(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (i >= 0 && i < LOGN) n += int'(dout_log[i]);
      return n;
   endfunction

   function automatic int readies(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (i >= 0 && i < LOGN) n += int'(ready_log[i]);
      return n;
   endfunction

   function automatic int log_at(input int which, input int i);
      if (i < 0 || i >= LOGN) return -1;
      case (which)
         0: return int'(dout_log[i]);
         1: return int'(ready_log[i]);
         default: return int'(und_log[i]);
      endcase
   endfunction

   // ---------------- stimulus tasks ----------------
   // Offer a word and return the cycle in which the handshake was seen.
   task automatic handshake(input logic [23:0] d, input logic l, input int limit, output int hs);
      pix_data = d;
      pix_last = l;
      pix_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge osc25m);
         if (pix_ready) begin
            hs = cyc;
            break;
         end
      end
      @(posedge osc25m);
      #1;
      if (hs < 0) chk("handshake_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge osc25m);
         if (pix_ready && !busy) begin
            at = cyc;
            break;
         end
      end
      @(posedge osc25m);
      #1;
      if (at < 0) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #(40 * 150000);
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, r, n, sel, gap;
      logic [31:0] rv;

      // Reset: three edges high, then a full latch interval before idle.
      repeat (3) @(posedge osc25m);
      #1 rst = 1'b0;
      n = 0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge osc25m);
         if (i == 0) begin
            chk("rst_dout", int'(dout), 0);
            chk("rst_busy", int'(busy), 1);
            chk("rst_ready", int'(pix_ready), 0);
            chk("rst_underrun", int'(underrun), 0);
         end
         if (pix_ready) break;
         n++;
      end
      chk("rst_latch_len", n, TLATCH);
      chk("rst_idle_busy", int'(busy), 0);
      @(posedge osc25m);
      #1;

      // Single last pixel AA0000.
      handshake(24'hAA0000, 1'b1, 10, c);
      pix_valid = 1'b0;
      wait_idle(3000, r);
      chk("single_ready_after", r - c, WORD + TLATCH + 1);
      chk("single_first_cycle_low", log_at(0, c + 1), 0);
      chk("single_bit23_high", run_len(c + 2), T1H);
      chk("single_bit22_high", run_len(c + 2 + TBIT), T0H);
      chk("single_bit15_high", run_len(c + 2 + 8 * TBIT), T0H);
      chk("single_total_high", ones(c + 1, r), 4 * T1H + 20 * T0H);

      // Back-to-back FFFFFF then 000000 with valid held high.
      handshake(24'hFFFFFF, 1'b0, 10, c);
      handshake(24'h000000, 1'b1, 800, c2);
      pix_valid = 1'b0;
      chk("b2b_second_accept", c2 - c, WORD);
      wait_idle(3000, r);
      chk("b2b_p1_first_high", run_len(c + 2), T1H);
      chk("b2b_p2_first_high", run_len(c + 2 + WORD), T0H);
      chk("b2b_total_high", ones(c + 1, c + 2 + 2 * WORD), 24 * T1H + 24 * T0H);
      chk("b2b_ready_pulses", readies(c + 1, c + WORD), 1);

      // Underrun after a non-last pixel.
      handshake(24'h00FF00, 1'b0, 10, c);
      pix_valid = 1'b0;
      wait_idle(1000, r);
      repeat (2) begin @(posedge osc25m); #1; end
      chk("und_idle_at", r - c, WORD + 1);
      chk("und_pulse", log_at(2, c + WORD + 1), 1);
      chk("und_before", log_at(2, c + WORD), 0);
      chk("und_after", log_at(2, c + WORD + 2), 0);
      chk("und_dout_low", log_at(0, c + WORD + 1), 0);
      chk("und_ready_window", readies(c + 1, c + WORD), 1);

      // Reset in bit 20, cycle 5, while the line is high.
      handshake(24'h5AC396, 1'b1, 10, c);
      pix_valid = 1'b0;
      repeat (98) @(posedge osc25m);
      #1 rst = 1'b1;
      @(posedge osc25m);
      #1 rst = 1'b0;
      wait_idle(2200, r);
      chk("midrst_dout_before", log_at(0, c + 99), 1);
      chk("midrst_dout_after", log_at(0, c + 100), 0);
      chk("midrst_idle_at", r - c, 99 + TLATCH + 1);
      handshake(24'h5AC396, 1'b1, 10, c2);
      pix_valid = 1'b0;
      wait_idle(3000, r);
      chk("midrst_resend_bit23", run_len(c2 + 2), T0H);
      chk("midrst_resend_bit22", run_len(c2 + 2 + TBIT), T1H);

      // Valid offered during the latch interval.
      handshake(24'h123456, 1'b1, 10, c);
      pix_valid = 1'b0;
      repeat (50) begin @(posedge osc25m); #1; end
      handshake(24'h800001, 1'b1, 3000, c2);
      pix_valid = 1'b0;
      chk("latch_hold_accept", c2 - c, WORD + TLATCH + 1);
      wait_idle(3000, r);
      chk("latch_hold_no_ready", readies(c + 1, c2 - 1), 0);
      chk("latch_hold_rise_low", log_at(0, c2 + 1), 0);
      chk("latch_hold_rise", run_len(c2 + 2), T1H);

      // Randomised words, gaps, chaining and resets against the model.
      for (int w = 0; w < 14; w++) begin
         rv = $urandom;
         handshake(rv[23:0], ($urandom_range(0, 3) == 0), 3000, c);
         sel = $urandom_range(0, 7);
         if (sel == 0) begin
            pix_valid = 1'b0;
            gap = $urandom_range(1, 700);
            repeat (gap) begin @(posedge osc25m); #1; end
            rst = 1'b1;
            gap = $urandom_range(1, 3);
            repeat (gap) begin @(posedge osc25m); #1; end
            rst = 1'b0;
         end else if (sel >= 4) begin
            pix_valid = 1'b0;
            rv = $urandom;
            pix_data = rv[23:0];
            pix_last = rv[24];
            gap = $urandom_range(0, 800);
            repeat (gap) begin @(posedge osc25m); #1; end
         end
      end
      pix_valid = 1'b0;
      wait_idle(3000, r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
